// File: rtl/bus_rr_scheduler.sv
// Round-robin bus ownership scheduler: registered one-hot grant, one-cycle owner turnaround,
// and a stall watchdog that revokes and masks a master whose slave never answers.
module bus_rr_scheduler #(
  parameter int NUM_MASTERS = 2,
  parameter int SEL_W       = $clog2(NUM_MASTERS),
  parameter int TIMEOUT     = 255,
  parameter int TO_W        = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] breq,
  input  logic                   bus_valid,
  input  logic                   bus_ready,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [SEL_W-1:0]       m_sel,
  output logic                   bus_busy,
  output logic                   timeout_evt
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_MAX = '1;
  localparam logic [NUM_MASTERS-1:0] ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  state_t                 state;
  logic [SEL_W-1:0]       last;
  logic [NUM_MASTERS-1:0] mask;
  logic [TO_W-1:0]        stall_cnt;

  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] revoke_bit;
  logic [SEL_W-1:0]       cand;
  logic [SEL_W-1:0]       winner;
  logic                   win_vld;
  logic                   stalled;
  logic                   owner_req;
  logic                   expire;

  assign elig      = breq & ~mask;
  assign stalled   = bus_valid & ~bus_ready;
  assign owner_req = breq[m_sel];
  assign expire    = (TIMEOUT != 0) && stalled && (stall_cnt == TO_LAST);

  // Walk downwards from the farthest candidate so the nearest eligible one after last wins.
  always_comb begin
    winner  = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = SEL_W'((int'(last) + k) % NUM_MASTERS);
      if (elig[cand]) begin
        winner  = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    revoke_bit = '0;
    if (state == GRANT && owner_req && expire) begin
      revoke_bit = ONE << m_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= SEL_W'(NUM_MASTERS - 1);
      mask        <= '0;
      stall_cnt   <= '0;
      bgrant      <= '0;
      m_sel       <= '0;
      bus_busy    <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      // A mask bit survives only while its master keeps breq asserted.
      mask        <= (mask & breq) | revoke_bit;
      case (state)
        IDLE, TURN: begin
          stall_cnt <= '0;
          if (win_vld) begin
            state    <= GRANT;
            bgrant   <= ONE << winner;
            m_sel    <= winner;
            last     <= winner;
            bus_busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (!owner_req || expire) begin
            state       <= TURN;
            bgrant      <= '0;
            bus_busy    <= 1'b0;
            stall_cnt   <= '0;
            timeout_evt <= owner_req;
          end else if (stalled) begin
            stall_cnt <= (stall_cnt == CNT_MAX) ? stall_cnt : stall_cnt + TO_W'(1);
          end else begin
            stall_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          bgrant   <= '0;
          bus_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Bench for bus_rr_scheduler: directed literal scenarios plus randomized traffic,
// checked every cycle against a behavioural ownership model.
module tb_bus_rr_scheduler;

  localparam int N  = 3;
  localparam int SW = 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  breq;
  logic          bus_valid;
  logic          bus_ready;
  logic [N-1:0]  bgrant;
  logic [SW-1:0] m_sel;
  logic          bus_busy;
  logic          timeout_evt;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: who owns the bus (-1 = nobody), rotation pointer, mask, stall run.
  int           m_owner;
  int           m_last;
  logic [N-1:0] m_mask;
  int           m_stall;
  int           m_sel_q;
  logic         m_tevt;
  bit           started = 0;

  int t4_exp [8] = '{1, 1, 1, 0, 2, 2, 2, 0};

  bus_rr_scheduler #(
    .NUM_MASTERS(N),
    .SEL_W      (SW),
    .TIMEOUT    (TO),
    .TO_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .breq       (breq),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bgrant     (bgrant),
    .m_sel      (m_sel),
    .bus_busy   (bus_busy),
    .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int pick(input logic [N-1:0] e, input int from);
    for (int k = 1; k <= N; k++) begin
      if (e[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] e;
    int w;
    bit st;
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_mask = '0; m_stall = 0; m_sel_q = 0; m_tevt = 1'b0;
    end else begin
      e      = breq & ~m_mask;
      st     = bus_valid && !bus_ready;
      m_tevt = 1'b0;
      m_mask = m_mask & breq;
      if (m_owner >= 0) begin
        if (!breq[m_owner]) begin
          m_owner = -1;
        end else if (st && (m_stall + 1 == TO)) begin
          m_mask[m_owner] = 1'b1;
          m_tevt  = 1'b1;
          m_owner = -1;
        end else begin
          m_stall = st ? m_stall + 1 : 0;
        end
      end else begin
        w = pick(e, m_last);
        if (w >= 0) begin
          m_owner = w; m_sel_q = w; m_last = w; m_stall = 0;
        end
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("mdl_bgrant", bgrant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("mdl_m_sel", m_sel, m_sel_q);
      chk("mdl_busy", bus_busy, (m_owner >= 0) ? 1 : 0);
      chk("mdl_tevt", timeout_evt, m_tevt);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; breq = 3'b011; bus_valid = 1'b0; bus_ready = 1'b1;

    // Reset held with requests pending
    repeat (2) begin
      @(negedge clk);
      chk("rst_bgrant", bgrant, 0);
      chk("rst_m_sel", m_sel, 0);
      chk("rst_busy", bus_busy, 0);
      chk("rst_tevt", timeout_evt, 0);
    end

    // Single requester, one-cycle latency, release
    rst = 1'b0; breq = 3'b001;
    @(negedge clk); chk("t2_grant", bgrant, 1);
    repeat (4) @(negedge clk);
    breq = 3'b000;
    @(negedge clk); chk("t2_release", bgrant, 0); chk("t2_busy", bus_busy, 0);

    // Two requesters out of reset, handover with turnaround
    do_reset();
    breq = 3'b011;
    @(negedge clk); chk("t3_first", bgrant, 1); chk("t3_first_sel", m_sel, 0);
    breq = 3'b010;
    @(negedge clk); chk("t3_turn", bgrant, 0); chk("t3_turn_sel", m_sel, 0);
    @(negedge clk); chk("t3_second", bgrant, 2); chk("t3_second_sel", m_sel, 1);

    // Alternation with immediate re-request after 3-cycle holds
    breq = 3'b000;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      breq = (k % 8 == 3) ? 3'b010 : (k % 8 == 7) ? 3'b001 : 3'b011;
      @(negedge clk);
      chk("t4_seq", bgrant, t4_exp[k % 8]);
    end

    // Stall watchdog
    breq = 3'b000; bus_valid = 1'b0;
    do_reset();
    breq = 3'b011; bus_valid = 1'b1; bus_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("t5_hold", bgrant, 1); chk("t5_hold_tevt", timeout_evt, 0);
    end
    @(negedge clk); chk("t5_revoke", bgrant, 0); chk("t5_revoke_tevt", timeout_evt, 1);
    bus_valid = 1'b0;
    @(negedge clk); chk("t5_next", bgrant, 2); chk("t5_next_tevt", timeout_evt, 0);
    chk("t5_next_sel", m_sel, 1);
    breq = 3'b001;
    repeat (3) begin
      @(negedge clk); chk("t5_masked", bgrant, 0);
    end
    breq = 3'b000;
    @(negedge clk);
    breq = 3'b001;
    @(negedge clk); chk("t5_regrant", bgrant, 1);

    // Reset while master 1 owns the bus
    breq = 3'b010;
    @(negedge clk);
    @(negedge clk); chk("t6_pre", bgrant, 2);
    rst = 1'b1; breq = 3'b011;
    @(negedge clk); chk("t6_rst", bgrant, 0); chk("t6_rst_sel", m_sel, 0);
    rst = 1'b0;
    @(negedge clk); chk("t6_after", bgrant, 1);

    // Randomized traffic with stalls and occasional resets
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5) == 0) breq[i] = ~breq[i];
      end
      bus_valid = ($urandom_range(9) < 8);
      bus_ready = ($urandom_range(9) < 3);
      rst       = ($urandom_range(199) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
